// File: rtl/trainer_pkg.sv
// Shared gate codes, truth-table signatures and identifier FSM states.
// Pure declarations, no timing.
// Imported by the trainer kit and by the gate identifier.
package trainer_pkg;

    // Gate-select codes understood by the trainer kit
    localparam logic [2:0] GATE_AND  = 3'b000;
    localparam logic [2:0] GATE_OR   = 3'b001;
    localparam logic [2:0] GATE_NOTA = 3'b010;
    localparam logic [2:0] GATE_NAND = 3'b011;
    localparam logic [2:0] GATE_NOR  = 3'b100;
    localparam logic [2:0] GATE_XOR  = 3'b101;
    localparam logic [2:0] GATE_XNOR = 3'b110;
    localparam logic [2:0] GATE_ZERO = 3'b111;

    // Truth-table signatures; bit i is y for input vector i = {a,b}
    localparam logic [3:0] SIG_AND  = 4'b1000;
    localparam logic [3:0] SIG_OR   = 4'b1110;
    localparam logic [3:0] SIG_NOTA = 4'b0011;
    localparam logic [3:0] SIG_NAND = 4'b0111;
    localparam logic [3:0] SIG_NOR  = 4'b0001;
    localparam logic [3:0] SIG_XOR  = 4'b0110;
    localparam logic [3:0] SIG_XNOR = 4'b1001;
    localparam logic [3:0] SIG_ZERO = 4'b0000;

    // Identifier run phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DECODE = 2'd2
    } state_t;

endpackage

// File: rtl/gate_identifier_if.sv
// Handshake and result bundle between the gate identifier and its host.
// No logic; carries control, probe and result signals.
// Host drives start and returns the DUT output on probe_y.
interface gate_identifier_if;
    logic       start;
    logic       probe_y;
    logic       probe_a;
    logic       probe_b;
    logic       busy;
    logic       done;
    logic [2:0] sel_out;
    logic       id_valid;
    logic [3:0] signature;

    // Host side: requests runs, feeds back the DUT output, reads results
    modport master (
        output start, probe_y,
        input  probe_a, probe_b, busy, done, sel_out, id_valid, signature
    );

    // Identifier side
    modport slave (
        input  start, probe_y,
        output probe_a, probe_b, busy, done, sel_out, id_valid, signature
    );
endinterface

// File: rtl/gate_sig_decode.sv
// Maps a 4-bit truth-table signature onto the trainer gate-select code.
// Purely combinational, zero latency.
// No flow control; unknown signatures report GATE_ZERO with valid low.
module gate_sig_decode
    import trainer_pkg::*;
(
    input  logic [3:0] sig,
    output logic [2:0] sel,
    output logic       valid
);

    // Signature lookup; constant-zero is a recognised gate, so valid is separate
    always_comb begin
        sel   = GATE_ZERO;
        valid = 1'b1;
        case (sig)
            SIG_AND:  sel = GATE_AND;
            SIG_OR:   sel = GATE_OR;
            SIG_NOTA: sel = GATE_NOTA;
            SIG_NAND: sel = GATE_NAND;
            SIG_NOR:  sel = GATE_NOR;
            SIG_XOR:  sel = GATE_XOR;
            SIG_XNOR: sel = GATE_XNOR;
            SIG_ZERO: sel = GATE_ZERO;
            default: begin
                sel   = GATE_ZERO;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/gate_identifier.sv
// Reverse trainer: sweeps a 2-input DUT through 4 vectors and names the gate.
// Results and done appear 4*SETTLE_CYCLES+2 cycles after start is sampled.
// start is ignored while busy; no other flow control, probe_y must be same-clock.
module gate_identifier
    import trainer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4   // cycles each vector is held, 1..255
) (
    input  logic               clk,
    input  logic               rst,
    gate_identifier_if.slave   bus
);

    localparam int             CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cap_q, cap_d;
    logic          probe_a_q, probe_a_d;
    logic          probe_b_q, probe_b_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    sel_q, sel_d;
    logic          valid_q, valid_d;
    logic [3:0]    sig_q, sig_d;

    logic [2:0]    dec_sel;
    logic          dec_valid;
    logic          settle_last;

    assign settle_last = (cnt_q == CNT_LAST);

    gate_sig_decode u_decode (
        .sig   (cap_q),
        .sel   (dec_sel),
        .valid (dec_valid)
    );

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            cap_q     <= 4'd0;
            probe_a_q <= 1'b0;
            probe_b_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_q     <= GATE_ZERO;
            valid_q   <= 1'b0;
            sig_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            probe_a_q <= probe_a_d;
            probe_b_q <= probe_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            sig_q     <= sig_d;
        end
    end

    // Next state: accept start only in IDLE, leave SETTLE after the last vector
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETTLE;
            SETTLE:  if (settle_last && idx_q == 2'd3) state_d = DECODE;
            DECODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: probes are computed one cycle ahead so they are registered
    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        probe_a_d = 1'b0;
        probe_b_d = 1'b0;
        done_d    = 1'b0;
        sel_d     = sel_q;
        valid_d   = valid_q;
        sig_d     = sig_q;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d = 2'd0;
                    cnt_d = '0;
                    cap_d = 4'd0;
                end
            end
            SETTLE: begin
                if (settle_last) begin
                    cap_d[idx_q] = bus.probe_y;
                    cnt_d        = '0;
                    if (idx_q != 2'd3) begin
                        idx_d     = idx_q + 2'd1;
                        probe_a_d = idx_d[1];
                        probe_b_d = idx_d[0];
                    end
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    probe_a_d = idx_q[1];
                    probe_b_d = idx_q[0];
                end
            end
            DECODE: begin
                sel_d   = dec_sel;
                valid_d = dec_valid;
                sig_d   = cap_q;
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.probe_a   = probe_a_q;
    assign bus.probe_b   = probe_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sel_out   = sel_q;
    assign bus.id_valid  = valid_q;
    assign bus.signature = sig_q;

endmodule

// File: tb/tb_gate_identifier.sv
module tb_gate_identifier;

    logic clk;
    logic rst;

    int   n_chk  = 0;
    int   n_pass = 0;

    // Trainer gate model controls for the S=4 instance
    int         dut_sel   = 0;
    bit         force_one = 0;
    bit         tt_mode   = 0;
    logic [3:0] tt_val    = 4'd0;

    gate_identifier_if ifa ();
    gate_identifier_if ifb ();

    gate_identifier #(.SETTLE_CYCLES(4)) u_dut_s4 (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    gate_identifier #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural trainer gate: code -> boolean function
    function automatic logic gate_fn(input int sel, input logic a, input logic b);
        case (sel)
            0:       return a & b;
            1:       return a | b;
            2:       return ~a;
            3:       return ~(a & b);
            4:       return ~(a | b);
            5:       return a ^ b;
            6:       return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    assign ifa.probe_y = force_one ? 1'b1 :
                         tt_mode   ? tt_val[{ifa.probe_a, ifa.probe_b}] :
                                     gate_fn(dut_sel, ifa.probe_a, ifa.probe_b);
    assign ifb.probe_y = gate_fn(3, ifb.probe_a, ifb.probe_b);

    // Known signatures listed in code order
    logic [3:0] known_sig [8] = '{4'h8, 4'hE, 4'h3, 4'h7, 4'h1, 4'h6, 4'h9, 4'h0};

    // Reference identification: returns {valid, code}
    function automatic logic [3:0] ref_lookup(input logic [3:0] sig);
        for (int i = 0; i < 8; i++)
            if (known_sig[i] == sig) return {1'b1, 3'(i)};
        return {1'b0, 3'b111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One run on the S=4 instance; k counts cycles after the edge that sampled start
    task automatic run_a(input int restart_k, output int done_k, output int ndone, output int busy_len);
        int first_idle;
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        done_k     = -1;
        ndone      = 0;
        first_idle = -1;
        for (int k = 1; k <= 25; k++) begin
            if (ifa.done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (!ifa.busy && first_idle < 0) first_idle = k;
            ifa.start = (k == restart_k);
            @(negedge clk);
        end
        ifa.start = 1'b0;
        busy_len  = first_idle - 1;
    endtask

    typedef struct {
        int         sel;
        logic [3:0] sig;
        logic [2:0] code;
        logic       valid;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int done_k, ndone, busy_len;
        logic [3:0] r;

        vecs[0] = '{0, 4'h8, 3'b000, 1'b1};
        vecs[1] = '{1, 4'hE, 3'b001, 1'b1};
        vecs[2] = '{2, 4'h3, 3'b010, 1'b1};
        vecs[3] = '{3, 4'h7, 3'b011, 1'b1};
        vecs[4] = '{4, 4'h1, 3'b100, 1'b1};
        vecs[5] = '{5, 4'h6, 3'b101, 1'b1};
        vecs[6] = '{6, 4'h9, 3'b110, 1'b1};
        vecs[7] = '{7, 4'h0, 3'b111, 1'b1};

        rst       = 1'b1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  ifa.busy, 0);
        check("rst_done",  ifa.done, 0);
        check("rst_probe", {ifa.probe_a, ifa.probe_b}, 0);
        check("rst_sel",   ifa.sel_out, 3'b111);
        check("rst_valid", ifa.id_valid, 0);
        check("rst_sig",   ifa.signature, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", ifa.busy, 0);

        // Sweep all trainer gates
        for (int i = 0; i < 8; i++) begin
            dut_sel = vecs[i].sel;
            run_a(0, done_k, ndone, busy_len);
            check("sweep_done_at", done_k, 18);
            check("sweep_ndone",   ndone, 1);
            check("sweep_busy",    busy_len, 17);
            check("sweep_sig",     ifa.signature, vecs[i].sig);
            check("sweep_sel",     ifa.sel_out, vecs[i].code);
            check("sweep_valid",   ifa.id_valid, vecs[i].valid);
        end

        // Constant-1 output is not a known gate
        force_one = 1'b1;
        run_a(0, done_k, ndone, busy_len);
        force_one = 1'b0;
        check("one_sig",   ifa.signature, 4'hF);
        check("one_sel",   ifa.sel_out, 3'b111);
        check("one_valid", ifa.id_valid, 0);
        check("one_ndone", ndone, 1);

        // start during a run is ignored
        dut_sel = 3;
        run_a(5, done_k, ndone, busy_len);
        check("restart_done_at", done_k, 18);
        check("restart_ndone",   ndone, 1);
        check("restart_busy",    busy_len, 17);
        check("restart_sel",     ifa.sel_out, 3'b011);

        // Reset seven cycles into a run
        dut_sel = 5;
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",  ifa.busy, 0);
        check("mid_rst_probe", {ifa.probe_a, ifa.probe_b}, 0);
        check("mid_rst_sel",   ifa.sel_out, 3'b111);
        check("mid_rst_valid", ifa.id_valid, 0);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            if (ifa.done) ndone++;
            @(negedge clk);
        end
        check("mid_rst_nodone", ndone, 0);
        run_a(0, done_k, ndone, busy_len);
        check("post_rst_done_at", done_k, 18);
        check("post_rst_sel",     ifa.sel_out, 3'b101);
        check("post_rst_valid",   ifa.id_valid, 1);

        // S=1 instance with a NAND DUT
        @(negedge clk);
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        done_k = -1;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 4) check("s1_probe", {ifb.probe_a, ifb.probe_b}, k - 1);
            if (k == 5) check("s1_decode_probe", {ifb.probe_a, ifb.probe_b}, 0);
            if (k <= 5) check("s1_busy", ifb.busy, 1);
            if (ifb.done && done_k < 0) done_k = k;
            @(negedge clk);
        end
        check("s1_done_at", done_k, 6);
        check("s1_sel",     ifb.sel_out, 3'b011);
        check("s1_sig",     ifb.signature, 4'h7);

        // Back-to-back: start in the done cycle of an OR run, then NOT a
        dut_sel = 1;
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        done_k = -1;
        for (int k = 1; k <= 30 && done_k < 0; k++) begin
            if (ifa.done) done_k = k;
            else @(negedge clk);
        end
        check("b2b_first_done", done_k, 18);
        check("b2b_first_sel",  ifa.sel_out, 3'b001);
        dut_sel   = 2;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        done_k = -1;
        for (int k = 1; k <= 25; k++) begin
            if (k == 1)  check("b2b_accepted", ifa.busy, 1);
            if (k == 10) check("b2b_hold_sel", ifa.sel_out, 3'b001);
            if (k == 10) check("b2b_hold_sig", ifa.signature, 4'hE);
            if (ifa.done && done_k < 0) done_k = k;
            @(negedge clk);
        end
        check("b2b_second_done", done_k, 18);
        check("b2b_second_sel",  ifa.sel_out, 3'b010);

        // Random truth tables against the reference identification
        tt_mode = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tt_val = 4'($urandom_range(0, 15));
            r      = ref_lookup(tt_val);
            run_a(0, done_k, ndone, busy_len);
            check("rand_done_at", done_k, 18);
            check("rand_sig",     ifa.signature, tt_val);
            check("rand_sel",     ifa.sel_out, r[2:0]);
            check("rand_valid",   ifa.id_valid, r[3]);
        end
        tt_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gate_identifier.md
Name: gate_identifier

Overview:
Sequential "reverse trainer" block: it works out which logic gate a device under test (DUT) implements.
- Drives the two DUT inputs through all four (a,b) combinations and samples the DUT output after a settle delay.
- Builds a 4-bit truth-table signature and decodes it into the same 3-bit gate-select code the trainer kit uses.
- Sits beside the gate-selectable trainer: probe_a/probe_b feed its a/b, and its y returns on probe_y. This allows automatic self-check and student-quiz modes.

Parameters:
SETTLE_CYCLES, 4, clock cycles each input vector is held before probe_y is sampled; legal range 1..255.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin an identification run
probe_y  input  1  DUT output being characterised
probe_a  output  1  drives DUT input a
probe_b  output  1  drives DUT input b
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse when results update
sel_out  output  3  identified gate code
id_valid  output  1  1 = signature matched a known gate
signature  output  4  captured truth table; bit i = y for vector i

Behaviour:
- Vector order, by index i = {a,b}: i0=(0,0), i1=(0,1), i2=(1,0), i3=(1,1).
- Signature-to-code map:
  - AND: 4'b1000 -> 3'b000
  - OR: 4'b1110 -> 3'b001
  - NOT a: 4'b0011 -> 3'b010
  - NAND: 4'b0111 -> 3'b011
  - NOR: 4'b0001 -> 3'b100
  - XOR: 4'b0110 -> 3'b101
  - XNOR: 4'b1001 -> 3'b110
  - constant 0: 4'b0000 -> 3'b111
- All 8 mappings set id_valid=1. Any other signature gives sel_out=3'b111 and id_valid=0.
- States:
  - IDLE: start=1 -> SETTLE, with idx=0 and cnt=0.
  - SETTLE: probe_a=idx[1], probe_b=idx[0], and cnt increments each cycle. When cnt==SETTLE_CYCLES-1, signature[idx] takes probe_y on that edge; cnt resets to 0. If idx==3 the state goes to DECODE; otherwise idx increments and the state stays in SETTLE.
  - DECODE: one cycle. On its closing edge sel_out, id_valid, signature and done=1 are registered, and the state returns to IDLE.
- Timing, with start sampled high at edge T:
  - busy=1 from cycle T+1 through T+4*S+1.
  - done=1 and the new results are visible in cycle T+4*S+2.
  - With S=4, done rises 18 cycles after start.
- probe_a and probe_b are registered outputs, 0 in IDLE and DECODE. Each vector is held for exactly S cycles.
- Signature handling: the internal capture register is cleared when a run is accepted. The signature output updates only at DECODE, together with sel_out.
- start while busy is ignored and does not restart the run. start in the done cycle (state already IDLE) is accepted.
- sel_out, id_valid and signature hold their values until the next DECODE.
- probe_y is sampled directly with no synchronizer; a DUT driven from the same clock domain is required.
- Reset values: probe_a=0, probe_b=0, busy=0, done=0, sel_out=3'b111, id_valid=0, signature=0, state IDLE.
- Reset mid-run aborts immediately with no done pulse.
- Counter width: $clog2(SETTLE_CYCLES+1); idx is 2 bits.

Decomposition:
- Shared package trainer_pkg holds:
  - gate code localparams GATE_AND..GATE_XNOR and GATE_ZERO=3'b111;
  - the 8 signature constants SIG_AND etc.;
  - the FSM state enum (IDLE, SETTLE, DECODE).
- The trainer kit and this block both import the code constants.
- One combinational sub-module, gate_sig_decode: 4-bit signature in, sel and valid out.

Test Plan:
- The bench connects the trainer gate model as DUT.
- Sweep DUT sel=0..7, S=4, one start pulse each -> done at start+18; sel_out equals the DUT sel and id_valid=1. Signatures: 8, E, 3, 7, 1, 6, 9, 0.
- probe_y forced to constant 1 -> signature=4'hF, sel_out=3'b111, id_valid=0, done pulses once.
- Second start pulse 5 cycles into a run -> no restart: single done at original start+18, busy stays continuous.
- rst asserted 7 cycles after start (S=4) -> next cycle busy=0, probe_a=probe_b=0, sel_out=3'b111, no done. A fresh run then identifies XOR correctly.
- S=1, DUT=NAND -> probe_a/probe_b step 00, 01, 10, 11 on consecutive cycles; done at start+6, sel_out=3'b011.
- Back-to-back runs with start asserted in the done cycle -> second run accepted; previous results hold until the second done.
